btn_dir_queue: RTL and testbench

Converts the four debounced direction buttons into a queue of discrete direction commands for the Pacman movement logic. Detects rising edges and held-button auto-repeat, encodes them, and buffers them in a small FIFO. Results are presented over a valid/ready handshake so no press is lost while the game engine is mid-tile. Sits between the per-button debouncers and the movement/game FSM.

---
 rtl/pacman_pkg.sv | 34 +++
 rtl/dir_fifo.sv | 72 +++++++
 rtl/btn_dir_queue.sv | 108 ++++++++++
 tb/tb_btn_dir_queue.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pacman_pkg.sv
// Shared Pacman definitions: direction encoding reused by the movement FSM,
// button timing defaults and small direction helpers.
package pacman_pkg;

    typedef logic [1:0] dir_t;

    localparam dir_t DIR_UP    = 2'd0;
    localparam dir_t DIR_DOWN  = 2'd1;
    localparam dir_t DIR_LEFT  = 2'd2;
    localparam dir_t DIR_RIGHT = 2'd3;

    // 250 ms at 100 MHz
    localparam int REPEAT_CYCLES_DEFAULT = 25_000_000;

    // Button vector bit order is {right, left, down, up}, so bit index equals code.
    function automatic dir_t prio_dir(input logic [3:0] btns);
        dir_t d;
        if (btns[0]) begin
            d = DIR_UP;
        end else if (btns[1]) begin
            d = DIR_DOWN;
        end else if (btns[2]) begin
            d = DIR_LEFT;
        end else begin
            d = DIR_RIGHT;
        end
        return d;
    endfunction

    function automatic logic is_onehot(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
    endfunction

endpackage

// File: rtl/dir_fifo.sv
// Small synchronous FIFO for direction commands. Registered head and valid;
// a full FIFO accepts a push only when the head is popped on the same edge.
module dir_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 2,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop_req,
    output logic             valid,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count,
    output logic             drop
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic [CW-1:0]    count_nxt_s;
    logic             valid_r;
    logic             full_s;
    logic             do_push_s;
    logic             do_pop_s;
    logic             drop_s;

    // Handshake qualification and next occupancy.
    always_comb begin
        full_s    = (count_r == CW'(DEPTH));
        do_pop_s  = valid_r && pop_req;
        do_push_s = push && (!full_s || do_pop_s);
        drop_s    = push && full_s && !do_pop_s;
        case ({do_push_s, do_pop_s})
            2'b10:   count_nxt_s = count_r + CW'(1);
            2'b01:   count_nxt_s = count_r - CW'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Storage, pointers and occupancy; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
            valid_r  <= 1'b0;
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= wr_ptr_r + PW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            count_r <= count_nxt_s;
            valid_r <= (count_nxt_s != {CW{1'b0}});
        end
    end

    assign valid = valid_r;
    assign dout  = mem_r[rd_ptr_r];
    assign count = count_r;
    assign drop  = drop_s;

endmodule

// File: rtl/btn_dir_queue.sv
// Turns debounced direction buttons into queued direction commands: edge
// detection with fixed priority, single-button auto-repeat, and a small FIFO.
module btn_dir_queue
    import pacman_pkg::*;
#(
    parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEFAULT,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        btn_up,
    input  logic                        btn_down,
    input  logic                        btn_left,
    input  logic                        btn_right,
    input  logic                        dir_ready,
    input  logic                        ovf_clr,
    output logic                        dir_valid,
    output logic [1:0]                  dir_code,
    output logic [$clog2(FIFO_DEPTH):0] dir_count,
    output logic                        overflow
);

    localparam int RW = $clog2(REPEAT_CYCLES);

    logic [3:0]    btn_s;
    logic [3:0]    sync1_r;
    logic [3:0]    sync2_r;
    logic [3:0]    prev_r;
    logic [3:0]    rise_s;
    logic [RW-1:0] rpt_cnt_r;
    logic [RW-1:0] rpt_cnt_nxt_s;
    logic          rpt_fire_s;
    logic          cmd_valid_s;
    dir_t          cmd_dir_s;
    logic          fifo_drop_s;
    logic          overflow_r;

    assign btn_s = {btn_right, btn_left, btn_down, btn_up};

    // Two-flop synchronizer plus previous-value register for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 4'b0000;
            sync2_r <= 4'b0000;
            prev_r  <= 4'b0000;
        end else begin
            sync1_r <= btn_s;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
        end
    end

    // Edge/repeat command generation; the repeat counter is 0 on any edge cycle.
    always_comb begin
        rise_s        = sync2_r & ~prev_r;
        rpt_fire_s    = 1'b0;
        rpt_cnt_nxt_s = {RW{1'b0}};
        if ((sync2_r != prev_r) || !is_onehot(sync2_r)) begin
            rpt_cnt_nxt_s = {RW{1'b0}};
        end else if (rpt_cnt_r == RW'(REPEAT_CYCLES - 1)) begin
            rpt_fire_s    = 1'b1;
            rpt_cnt_nxt_s = {RW{1'b0}};
        end else begin
            rpt_cnt_nxt_s = rpt_cnt_r + RW'(1);
        end
        cmd_valid_s = (rise_s != 4'b0000) || rpt_fire_s;
        if (rise_s != 4'b0000) begin
            cmd_dir_s = prio_dir(rise_s);
        end else begin
            cmd_dir_s = prio_dir(sync2_r);
        end
    end

    // Repeat counter and sticky, set-dominant overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_cnt_r  <= {RW{1'b0}};
            overflow_r <= 1'b0;
        end else begin
            rpt_cnt_r <= rpt_cnt_nxt_s;
            if (fifo_drop_s) begin
                overflow_r <= 1'b1;
            end else if (ovf_clr) begin
                overflow_r <= 1'b0;
            end else begin
                overflow_r <= overflow_r;
            end
        end
    end

    dir_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (2)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (cmd_valid_s),
        .din     (cmd_dir_s),
        .pop_req (dir_ready),
        .valid   (dir_valid),
        .dout    (dir_code),
        .count   (dir_count),
        .drop    (fifo_drop_s)
    );

    assign overflow = overflow_r;

endmodule

// File: tb/tb_btn_dir_queue.sv
// Randomised and directed bench for btn_dir_queue with a run-length based
// reference model feeding a scoreboard queue checked by an independent monitor.
module tb_btn_dir_queue;

    localparam int RC    = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          btn_up = 1'b0;
    logic          btn_down = 1'b0;
    logic          btn_left = 1'b0;
    logic          btn_right = 1'b0;
    logic          dir_ready = 1'b0;
    logic          ovf_clr = 1'b0;
    logic          dir_valid;
    logic [1:0]    dir_code;
    logic [CW-1:0] dir_count;
    logic          overflow;

    btn_dir_queue #(.REPEAT_CYCLES(RC), .FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .dir_ready (dir_ready),
        .ovf_clr   (ovf_clr),
        .dir_valid (dir_valid),
        .dir_code  (dir_code),
        .dir_count (dir_count),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   exp_q[$];
    int   m_count = 0;
    logic m_ovf = 1'b0;
    // Input samples from the last three edges: h0 newest.
    logic [3:0] h0 = 4'b0000;
    logic [3:0] h1 = 4'b0000;
    logic [3:0] h2 = 4'b0000;
    int   run_len = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int first_set(input logic [3:0] v);
        for (int i = 0; i < 4; i++) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    // Reference model: a button level seen at edge n-2 acts at edge n; a held
    // single button repeats every RC edges after its press.
    initial begin
        logic [3:0] lvl;
        logic [3:0] old;
        logic [3:0] rise;
        bit         have;
        bit         pop;
        bit         drop;
        int         code;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                exp_q.delete();
                m_count = 0;
                m_ovf   = 1'b0;
                h0 = 4'b0000;
                h1 = 4'b0000;
                h2 = 4'b0000;
                run_len = 0;
            end else begin
                lvl  = h1;
                old  = h2;
                rise = lvl & ~old;
                if (lvl == old) run_len++;
                else run_len = 1;
                have = 1'b0;
                code = 0;
                if (rise != 4'b0000) begin
                    have = 1'b1;
                    code = first_set(rise);
                end else if ($countones(lvl) == 1 && run_len > 1 && ((run_len - 1) % RC) == 0) begin
                    have = 1'b1;
                    code = first_set(lvl);
                end
                pop  = (m_count > 0) && dir_ready;
                drop = 1'b0;
                if (pop) m_count--;
                if (have) begin
                    if (m_count < DEPTH) begin
                        exp_q.push_back(code);
                        m_count++;
                    end else begin
                        drop = 1'b1;
                    end
                end
                if (drop) m_ovf = 1'b1;
                else if (ovf_clr) m_ovf = 1'b0;
                h2 = h1;
                h1 = h0;
                h0 = {btn_right, btn_left, btn_down, btn_up};
            end
        end
    end

    // Monitor: compares DUT state mid-cycle and retires commands on handshakes.
    initial begin
        int e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("count", 32'(dir_count), 32'(m_count));
                check("valid", 32'(dir_valid), 32'(m_count > 0));
                check("overflow", 32'(overflow), 32'(m_ovf));
                if (dir_valid) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL head: got code %0d expected no command at %0t", dir_code, $time);
                    end else begin
                        check("head", 32'(dir_code), 32'(exp_q[0]));
                        if (dir_ready) e = exp_q.pop_front();
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_btns(input logic [3:0] b);
        {btn_right, btn_left, btn_down, btn_up} = b;
    endtask

    task automatic press(input logic [3:0] b);
        set_btns(b);
        tick(2);
        set_btns(4'b0000);
        tick(2);
    endtask

    task automatic reset_pulse();
        #1 rst_n = 1'b0;
        #1;
        check("rst_valid", 32'(dir_valid), 32'd0);
        check("rst_count", 32'(dir_count), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        int pct;
        logic [3:0] rb;
        #1;
        check("reset_valid", 32'(dir_valid), 32'd0);
        check("reset_code", 32'(dir_code), 32'd0);
        check("reset_count", 32'(dir_count), 32'd0);
        check("reset_ovf", 32'(overflow), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        tick(1);

        // Single press of LEFT, no consumer.
        set_btns(4'b0100);
        tick(2);
        check("latency_not_yet", 32'(dir_valid), 32'd0);
        tick(1);
        check("latency_valid", 32'(dir_valid), 32'd1);
        check("latency_code", 32'(dir_code), 32'd2);
        tick(3);
        set_btns(4'b0000);
        tick(6);
        check("single_count", 32'(dir_count), 32'd1);
        dir_ready = 1'b1;
        tick(4);
        dir_ready = 1'b0;

        // DOWN and RIGHT together, held past the repeat period.
        set_btns(4'b1010);
        tick(20);
        set_btns(4'b0000);
        tick(4);
        check("simul_count", 32'(dir_count), 32'd1);
        check("simul_code", 32'(dir_code), 32'd1);
        dir_ready = 1'b1;
        tick(4);

        // Auto-repeat of UP with a ready consumer.
        set_btns(4'b0001);
        tick(30);
        set_btns(4'b0000);
        tick(6);
        dir_ready = 1'b0;

        // Overflow: five presses into a four-entry queue, then clear.
        press(4'b0100);
        press(4'b0001);
        press(4'b0010);
        press(4'b1000);
        press(4'b0001);
        tick(2);
        check("ovf_count", 32'(dir_count), 32'd4);
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_head", 32'(dir_code), 32'd2);
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        check("ovf_cleared", 32'(overflow), 32'd0);
        // Push coinciding with pop while full.
        set_btns(4'b1000);
        tick(2);
        dir_ready = 1'b1;
        tick(1);
        dir_ready = 1'b0;
        set_btns(4'b0000);
        check("full_pushpop_count", 32'(dir_count), 32'd4);
        check("full_pushpop_ovf", 32'(overflow), 32'd0);
        dir_ready = 1'b1;
        tick(6);
        dir_ready = 1'b0;

        // Ordering: UP, RIGHT, DOWN then drain.
        press(4'b0001);
        press(4'b1000);
        press(4'b0010);
        tick(2);
        dir_ready = 1'b1;
        tick(5);
        check("drain_valid", 32'(dir_valid), 32'd0);
        dir_ready = 1'b0;

        // Reset with commands queued, buttons low afterwards.
        press(4'b0001);
        press(4'b0100);
        press(4'b1000);
        tick(2);
        check("prereset_count", 32'(dir_count), 32'd3);
        reset_pulse();
        tick(12);
        // Reset while a button is held: exactly one command follows.
        set_btns(4'b0100);
        tick(5);
        reset_pulse();
        tick(5);
        set_btns(4'b0000);
        tick(3);
        check("held_reset_count", 32'(dir_count), 32'd1);
        dir_ready = 1'b1;
        tick(3);

        // Random traffic.
        pct = 50;
        for (int c = 0; c < 1500; c++) begin
            if (c % 100 == 0) begin
                case ($urandom_range(0, 2))
                    0:       pct = 10;
                    1:       pct = 50;
                    default: pct = 90;
                endcase
            end
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 3))
                    0:       rb = 4'b0000;
                    2:       rb = 4'($urandom_range(0, 15));
                    default: rb = 4'(1 << $urandom_range(0, 3));
                endcase
                set_btns(rb);
            end
            dir_ready = ($urandom_range(0, 99) < pct);
            ovf_clr   = ($urandom_range(0, 15) == 0);
            if (c == 750) reset_pulse();
            tick(1);
        end

        set_btns(4'b0000);
        ovf_clr   = 1'b0;
        dir_ready = 1'b1;
        tick(10);
        check("final_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
